// File: rtl/scope_capture_ram.sv
// Multi-channel oscilloscope capture buffer: circular sample RAM with pre-trigger
// depth, trigger-qualified stop and trigger-relative (oldest-first) readout.
module scope_capture_ram #(
  parameter int CH_NUM     = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int OUTPUT_REG = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         arm,
  input  logic [ADDR_WIDTH-1:0]        pretrig_len,
  input  logic                         smp_valid,
  input  logic [CH_NUM*DATA_WIDTH-1:0] smp_data,
  input  logic                         trig,
  output logic                         busy,
  output logic                         triggered,
  output logic                         done,
  output logic [ADDR_WIDTH-1:0]        trig_addr,
  input  logic                         rd_en,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  output logic [CH_NUM*DATA_WIDTH-1:0] rd_data,
  output logic                         rd_valid
);

  localparam int WW = CH_NUM * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] A_ZERO = '0;
  localparam logic [ADDR_WIDTH-1:0] A_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] A_MAX  = {ADDR_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  logic [WW-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] plen_q, plen_d;
  logic [ADDR_WIDTH-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_WIDTH-1:0] start_addr_q, start_addr_d;
  logic [ADDR_WIDTH-1:0] trig_addr_q, trig_addr_d;
  logic                  busy_q, busy_d;
  logic                  triggered_q, triggered_d;
  logic                  done_q, done_d;
  logic                  wr_en_s;
  logic [ADDR_WIDTH-1:0] phys_s;

  // Capture sequencing: next state, pointers and status flags
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    plen_d       = plen_q;
    post_cnt_d   = post_cnt_q;
    start_addr_d = start_addr_q;
    trig_addr_d  = trig_addr_q;
    wr_en_s      = 1'b0;
    if (arm) begin
      // The port is ADDR_WIDTH bits wide, so pretrig_len never exceeds DEPTH-1.
      wr_ptr_d = A_ZERO;
      cnt_d    = A_ZERO;
      plen_d   = pretrig_len;
      state_d  = (pretrig_len != A_ZERO) ? S_PRE : S_WAIT;
    end else begin
      case (state_q)
        S_PRE: begin
          if (smp_valid) begin
            wr_en_s  = 1'b1;
            wr_ptr_d = wr_ptr_q + A_ONE;
            cnt_d    = cnt_q + A_ONE;
            state_d  = (cnt_d == plen_q) ? S_WAIT : S_PRE;
          end else begin
            state_d = S_PRE;
          end
        end
        S_WAIT: begin
          if (smp_valid) begin
            wr_en_s  = 1'b1;
            wr_ptr_d = wr_ptr_q + A_ONE;
            if (trig) begin
              trig_addr_d  = wr_ptr_q;
              start_addr_d = wr_ptr_q - plen_q;
              post_cnt_d   = A_MAX - plen_q;
              state_d      = (post_cnt_d == A_ZERO) ? S_DONE : S_POST;
            end else begin
              state_d = S_WAIT;
            end
          end else begin
            state_d = S_WAIT;
          end
        end
        S_POST: begin
          if (smp_valid) begin
            wr_en_s    = 1'b1;
            wr_ptr_d   = wr_ptr_q + A_ONE;
            post_cnt_d = post_cnt_q - A_ONE;
            state_d    = (post_cnt_q == A_ONE) ? S_DONE : S_POST;
          end else begin
            state_d = S_POST;
          end
        end
        S_IDLE:  state_d = S_IDLE;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
    busy_d      = (state_d == S_PRE) || (state_d == S_WAIT) || (state_d == S_POST);
    triggered_d = (state_d == S_POST) || (state_d == S_DONE);
    done_d      = (state_d == S_DONE);
  end

  // Control and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= A_ZERO;
      cnt_q        <= A_ZERO;
      plen_q       <= A_ZERO;
      post_cnt_q   <= A_ZERO;
      start_addr_q <= A_ZERO;
      trig_addr_q  <= A_ZERO;
      busy_q       <= 1'b0;
      triggered_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      plen_q       <= plen_d;
      post_cnt_q   <= post_cnt_d;
      start_addr_q <= start_addr_d;
      trig_addr_q  <= trig_addr_d;
      busy_q       <= busy_d;
      triggered_q  <= triggered_d;
      done_q       <= done_d;
    end
  end

  // Sample RAM write port
  always_ff @(posedge clk) begin
    if (wr_en_s && !rst) begin
      mem[wr_ptr_q] <= smp_data;
    end
  end

  // Logical index 0 is the oldest sample of the capture.
  assign phys_s = start_addr_q + rd_addr;

  logic [WW-1:0] rd_data1_q;
  logic          rd_valid1_q;

  // Read port; non-blocking write above makes same-address accesses read-first
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data1_q  <= '0;
      rd_valid1_q <= 1'b0;
    end else begin
      rd_valid1_q <= rd_en;
      if (rd_en) begin
        rd_data1_q <= mem[phys_s];
      end
    end
  end

  generate
    if (OUTPUT_REG != 0) begin : g_oreg
      logic [WW-1:0] rd_data2_q;
      logic          rd_valid2_q;
      // Optional output stage, holds data when no read is in flight
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data2_q  <= '0;
          rd_valid2_q <= 1'b0;
        end else begin
          rd_valid2_q <= rd_valid1_q;
          if (rd_valid1_q) begin
            rd_data2_q <= rd_data1_q;
          end
        end
      end
      assign rd_data  = rd_data2_q;
      assign rd_valid = rd_valid2_q;
    end else begin : g_noreg
      assign rd_data  = rd_data1_q;
      assign rd_valid = rd_valid1_q;
    end
  endgenerate

  assign busy      = busy_q;
  assign triggered = triggered_q;
  assign done      = done_q;
  assign trig_addr = trig_addr_q;

endmodule

// File: tb/tb_scope_capture_ram.sv
// Directed bench for scope_capture_ram (DEPTH=16, two channels); a second
// instance with the output register shares all inputs.
module tb_scope_capture_ram;

  logic        clk;
  logic        rst;
  logic        arm;
  logic [3:0]  pretrig_len;
  logic        smp_valid;
  logic [15:0] smp_data;
  logic        trig;
  logic        rd_en;
  logic [3:0]  rd_addr;

  logic        busy, triggered, done, rd_valid;
  logic [3:0]  trig_addr;
  logic [15:0] rd_data;
  logic        busy2, triggered2, done2, rd_valid2;
  logic [3:0]  trig_addr2;
  logic [15:0] rd_data2;

  int total = 0;
  int bad   = 0;
  logic [15:0] rd_got [0:15];
  logic        rd_vgot [0:15];

  scope_capture_ram #(.CH_NUM(2), .DATA_WIDTH(8), .ADDR_WIDTH(4), .OUTPUT_REG(0)) u_dut (
    .clk(clk), .rst(rst), .arm(arm), .pretrig_len(pretrig_len),
    .smp_valid(smp_valid), .smp_data(smp_data), .trig(trig),
    .busy(busy), .triggered(triggered), .done(done), .trig_addr(trig_addr),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  scope_capture_ram #(.CH_NUM(2), .DATA_WIDTH(8), .ADDR_WIDTH(4), .OUTPUT_REG(1)) u_dut2 (
    .clk(clk), .rst(rst), .arm(arm), .pretrig_len(pretrig_len),
    .smp_valid(smp_valid), .smp_data(smp_data), .trig(trig),
    .busy(busy2), .triggered(triggered2), .done(done2), .trig_addr(trig_addr2),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2), .rd_valid(rd_valid2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] smp(input int k);
    logic [7:0] b;
    b = k[7:0];
    return {b + 8'h80, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [3:0] p);
    arm = 1'b1; pretrig_len = p; smp_valid = 1'b0; trig = 1'b0;
    tick();
    arm = 1'b0;
  endtask

  // Feed samples k=0,1,.. until done (bounded); optional invalid gap cycles carry trig=1
  task automatic capture(input int trig_k, input int ign_lo, input int ign_hi, input bit gap,
                         output int last_k, output int cycles);
    last_k = -1;
    cycles = 0;
    for (int k = 0; k < 40; k++) begin
      smp_valid = 1'b1;
      smp_data  = smp(k);
      trig      = (k == trig_k) || (k >= ign_lo && k <= ign_hi);
      tick();
      cycles++;
      if (gap) begin
        smp_valid = 1'b0; trig = 1'b1; smp_data = 16'hdead;
        tick();
        cycles++;
      end
      if (done) begin
        last_k = k;
        break;
      end
    end
    smp_valid = 1'b0;
    trig = 1'b0;
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      rd_addr = i[3:0];
      tick();
      rd_got[i]  = rd_data;
      rd_vgot[i] = rd_valid;
    end
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (triggered !== 1'b0) begin bad++; $display("FAIL reset_trig got=%0b exp=0", triggered); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
    total++; if (trig_addr !== 4'd0) begin bad++; $display("FAIL reset_taddr got=%0h exp=0", trig_addr); end
    total++; if (rd_data !== 16'h0)  begin bad++; $display("FAIL reset_rdata got=%0h exp=0", rd_data); end
    total++; if (rd_valid !== 1'b0)  begin bad++; $display("FAIL reset_rvalid got=%0b exp=0", rd_valid); end
    total++; if (rd_data2 !== 16'h0 || rd_valid2 !== 1'b0) begin
      bad++; $display("FAIL reset_dut2 got=%0h/%0b exp=0/0", rd_data2, rd_valid2);
    end
  endtask

  task automatic test_basic();
    int lk, cy;
    do_arm(4'd4);
    total++; if (busy !== 1'b1 || triggered !== 1'b0) begin
      bad++; $display("FAIL t1_armed got=%0b%0b exp=10", busy, triggered);
    end
    capture(10, 1, 0, 1'b0, lk, cy);
    total++; if (lk !== 21)           begin bad++; $display("FAIL t1_last_k got=%0d exp=21", lk); end
    total++; if (trig_addr !== 4'd10) begin bad++; $display("FAIL t1_taddr got=%0d exp=10", trig_addr); end
    total++; if (busy !== 1'b0 || triggered !== 1'b1) begin
      bad++; $display("FAIL t1_flags got=%0b%0b exp=01", busy, triggered);
    end
    read_all();
    for (int i = 0; i < 16; i++) begin
      total++; if (rd_got[i] !== smp(6 + i) || rd_vgot[i] !== 1'b1) begin
        bad++; $display("FAIL t1_read[%0d] got=%0h/%0b exp=%0h/1", i, rd_got[i], rd_vgot[i], smp(6 + i));
      end
    end
    total++; if (rd_got[4] !== 16'h8a0a) begin bad++; $display("FAIL t1_trig_sample got=%0h exp=8a0a", rd_got[4]); end
    tick();
    total++; if (rd_valid !== 1'b0 || rd_data !== smp(21)) begin
      bad++; $display("FAIL t1_hold got=%0h/%0b exp=%0h/0", rd_data, rd_valid, smp(21));
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL t1_done_held got=%0b exp=1", done); end
  endtask

  task automatic test_output_reg();
    rd_en = 1'b1; rd_addr = 4'd4;
    tick();
    rd_en = 1'b0;
    total++; if (rd_valid2 !== 1'b0 || rd_valid !== 1'b1) begin
      bad++; $display("FAIL oreg_cyc1 got=%0b/%0b exp=0/1", rd_valid2, rd_valid);
    end
    tick();
    total++; if (rd_valid2 !== 1'b1 || rd_data2 !== 16'h8a0a) begin
      bad++; $display("FAIL oreg_cyc2 got=%0h/%0b exp=8a0a/1", rd_data2, rd_valid2);
    end
    tick();
    total++; if (rd_valid2 !== 1'b0 || rd_data2 !== 16'h8a0a) begin
      bad++; $display("FAIL oreg_hold got=%0h/%0b exp=8a0a/0", rd_data2, rd_valid2);
    end
  endtask

  task automatic test_zero_pretrig();
    int lk, cy;
    do_arm(4'd0);
    capture(0, 1, 0, 1'b0, lk, cy);
    total++; if (lk !== 15)          begin bad++; $display("FAIL t2_last_k got=%0d exp=15", lk); end
    total++; if (trig_addr !== 4'd0) begin bad++; $display("FAIL t2_taddr got=%0d exp=0", trig_addr); end
    read_all();
    for (int i = 0; i < 16; i++) begin
      total++; if (rd_got[i] !== smp(i)) begin
        bad++; $display("FAIL t2_read[%0d] got=%0h exp=%0h", i, rd_got[i], smp(i));
      end
    end
  endtask

  task automatic test_pre_trig_ignored();
    int lk, cy;
    do_arm(4'd4);
    capture(7, 0, 3, 1'b0, lk, cy);
    total++; if (trig_addr !== 4'd7) begin bad++; $display("FAIL t3_taddr got=%0d exp=7", trig_addr); end
    total++; if (lk !== 18)          begin bad++; $display("FAIL t3_last_k got=%0d exp=18", lk); end
    read_all();
    total++; if (rd_got[0] !== 16'h8303) begin bad++; $display("FAIL t3_oldest got=%0h exp=8303", rd_got[0]); end
    total++; if (rd_got[15] !== 16'h9212) begin bad++; $display("FAIL t3_newest got=%0h exp=9212", rd_got[15]); end
  endtask

  task automatic test_max_pretrig();
    int lk, cy;
    do_arm(4'd15);
    capture(15, 1, 0, 1'b0, lk, cy);
    total++; if (lk !== 15)           begin bad++; $display("FAIL t4_last_k got=%0d exp=15", lk); end
    total++; if (trig_addr !== 4'd15) begin bad++; $display("FAIL t4_taddr got=%0d exp=15", trig_addr); end
    read_all();
    for (int i = 0; i < 16; i++) begin
      total++; if (rd_got[i] !== smp(i)) begin
        bad++; $display("FAIL t4_read[%0d] got=%0h exp=%0h", i, rd_got[i], smp(i));
      end
    end
  endtask

  task automatic test_gapped_valid();
    int lk, cy;
    do_arm(4'd4);
    capture(10, 1, 0, 1'b1, lk, cy);
    total++; if (lk !== 21)           begin bad++; $display("FAIL t5_last_k got=%0d exp=21", lk); end
    total++; if (cy !== 44)           begin bad++; $display("FAIL t5_cycles got=%0d exp=44", cy); end
    total++; if (trig_addr !== 4'd10) begin bad++; $display("FAIL t5_taddr got=%0d exp=10", trig_addr); end
    read_all();
    for (int i = 0; i < 16; i++) begin
      total++; if (rd_got[i] !== smp(6 + i)) begin
        bad++; $display("FAIL t5_read[%0d] got=%0h exp=%0h", i, rd_got[i], smp(6 + i));
      end
    end
  endtask

  task automatic test_restart_and_abort();
    int lk, cy;
    do_arm(4'd4);
    for (int k = 0; k <= 12; k++) begin
      smp_valid = 1'b1; smp_data = smp(k); trig = (k == 10);
      tick();
    end
    smp_valid = 1'b0; trig = 1'b0;
    total++; if (triggered !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL t6_in_post got=%0b%0b exp=11", busy, triggered);
    end
    do_arm(4'd2);
    total++; if (triggered !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL t6_rearm got=%0b%0b%0b exp=100", busy, triggered, done);
    end
    capture(5, 1, 0, 1'b0, lk, cy);
    total++; if (trig_addr !== 4'd5) begin bad++; $display("FAIL t6_taddr got=%0d exp=5", trig_addr); end
    total++; if (lk !== 18)          begin bad++; $display("FAIL t6_last_k got=%0d exp=18", lk); end
    do_arm(4'd0);
    smp_valid = 1'b1; smp_data = smp(0); trig = 1'b0;
    tick();
    smp_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL t6_wait_busy got=%0b exp=1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0 || triggered !== 1'b0) begin
      bad++; $display("FAIL t6_abort got=%0b%0b%0b exp=000", busy, triggered, done);
    end
    total++; if (busy2 !== 1'b0 || done2 !== 1'b0) begin
      bad++; $display("FAIL t6_abort_dut2 got=%0b%0b exp=00", busy2, done2);
    end
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; pretrig_len = 4'd0; smp_valid = 1'b0;
    smp_data = 16'h0; trig = 1'b0; rd_en = 1'b0; rd_addr = 4'd0;
    test_reset();
    test_basic();
    test_output_reg();
    test_zero_pretrig();
    test_pre_trig_ignored();
    test_max_pretrig();
    test_gapped_valid();
    test_restart_and_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
